shift_output_buffer: RTL and testbench

SHIFT_OUTPUT_BUFFER -- requirements
Module: shift_output_buffer

---
 rtl/shift_pkg.sv | 17 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/variable_shift_register.sv | 27 ++
 rtl/shift_output_buffer.sv | 66 ++++++
 tb/tb_shift_output_buffer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared defaults and helpers for the shift register output buffer slice.
package shift_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_SIZE  = 3;
    localparam int unsigned DEFAULT_DEPTH = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; storage is not reset.
module sync_fifo
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO is only legal when the head leaves on the same edge.
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/variable_shift_register.sv
// Upstream SIZE-stage data shift register advanced by ce; data only, no reset.
module variable_shift_register
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SIZE  = DEFAULT_SIZE
) (
    input  logic             clk,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [SIZE];

    always_ff @(posedge clk) begin
        if (ce) begin
            stage[0] <= din;
            for (int unsigned i = 1; i < SIZE; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[SIZE-1];

endmodule

// File: rtl/shift_output_buffer.sv
// Collects valid samples leaving the upstream shift register into an output FIFO,
// stalling the shift register only when a valid head word has nowhere to go.
module shift_output_buffer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SIZE  = DEFAULT_SIZE,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce_in,
    input  logic                   in_valid,
    output logic                   ce,
    input  logic [WIDTH-1:0]       sr_dout,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    logic [SIZE-1:0] vtag;
    logic [SIZE-1:0] vtag_next;
    logic            head_valid;
    logic            wr;
    logic            rd;

    assign head_valid = vtag[SIZE-1];
    // A full FIFO being read this cycle frees the slot the head word needs.
    assign ce         = ce_in & ~(head_valid & full & ~out_ready);
    assign wr         = ce & head_valid;
    assign rd         = out_valid & out_ready;
    assign out_valid  = ~empty;

    always_comb begin
        vtag_next    = vtag << 1;
        vtag_next[0] = in_valid;
    end

    // Tags follow the shift register stage for stage, so they advance only on ce.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vtag <= '0;
        end else if (ce) begin
            vtag <= vtag_next;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .rd    (rd),
        .din   (sr_dout),
        .dout  (out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_shift_output_buffer.sv
// Bench for shift_output_buffer driving a variable_shift_register, checked
// against a queue model every cycle plus directed literal expectations.
module tb_shift_output_buffer;
    import shift_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SIZE  = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ce_in = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             ce;
    logic [WIDTH-1:0] sr_dout;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    variable_shift_register #(.WIDTH(WIDTH), .SIZE(SIZE)) u_sr (
        .clk  (clk),
        .ce   (ce),
        .din  (din),
        .dout (sr_dout)
    );

    shift_output_buffer #(.WIDTH(WIDTH), .SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce_in     (ce_in),
        .in_valid  (in_valid),
        .ce        (ce),
        .sr_dout   (sr_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: upstream pipeline as sample/valid arrays, FIFO as a queue.
    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_pd [SIZE];
    bit               m_pv [SIZE];
    bit               m_ce_now;

    function automatic bit exp_ce();
        return ce_in && !(m_pv[SIZE-1] && (m_q.size() == DEPTH) && !out_ready);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            for (int i = 0; i < SIZE; i++) m_pv[i] = 1'b0;
        end else begin
            m_ce_now = exp_ce();
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (m_ce_now && m_pv[SIZE-1]) m_q.push_back(m_pd[SIZE-1]);
            if (m_ce_now) begin
                for (int i = SIZE - 1; i > 0; i--) begin
                    m_pd[i] = m_pd[i-1];
                    m_pv[i] = m_pv[i-1];
                end
                m_pd[0] = din;
                m_pv[0] = in_valid;
            end
        end
    end

    logic [WIDTH-1:0] got [$];

    always @(negedge clk) begin
        check("ce", ce, exp_ce());
        check("out_valid", out_valid, m_q.size() != 0);
        check("count", count, m_q.size());
        check("full", full, m_q.size() == DEPTH);
        check("empty", empty, m_q.size() == 0);
        if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
        if (rst && out_valid && out_ready) got.push_back(out_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic check_got(input string name, input logic [WIDTH-1:0] exp_words [$]);
        check({name, "_len"}, got.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < got.size(); i++) begin
            check(name, got[i], exp_words[i]);
        end
    endtask

    int peak;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with ce_in held high
        #1 rst = 1'b0;
        ce_in = 1'b1;
        #1;
        check("rst_ce", ce, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        steps(3);
        rst = 1'b1;
        steps(4);

        // Latency: sample presented after edge 0, accepted on edge 1
        din = 4'hA; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; din = '0;
        check("lat_e1", out_valid, 0);
        step();
        check("lat_e2", out_valid, 0);
        step();
        check("lat_e3", out_valid, 0);
        step();
        check("lat_e4_valid", out_valid, 1);
        check("lat_e4_data", out_data, 4'hA);
        step();
        check("lat_e5", out_valid, 0);

        // Backpressure: A..E back-to-back into a stalled consumer
        out_ready = 1'b0;
        got.delete();
        for (int k = 0; k < 5; k++) begin
            din = WIDTH'(4'hA + k); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0; din = '0;
        steps(2);
        check("bp_full", full, 1);
        check("bp_count", count, 4);
        check("bp_stall", ce, 0);
        check("bp_head", out_data, 4'hA);
        steps(2);
        check("bp_hold_count", count, 4);
        check("bp_hold_stall", ce, 0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ce", ce, 1);
        step();
        check("bp_after_count", count, 4);
        check("bp_after_head", out_data, 4'hB);
        check("bp_after_full", full, 1);
        steps(6);
        check_got("bp_order", '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE});

        // Bubbles: only valid samples reach the FIFO
        out_ready = 1'b0;
        got.delete();
        peak = 0;
        for (int k = 0; k < 4; k++) begin
            din      = (k == 0) ? 4'hA : (k == 2) ? 4'hB : 4'h0;
            in_valid = (k % 2) == 0;
            step();
            if (int'(count) > peak) peak = int'(count);
        end
        in_valid = 1'b0; din = '0;
        repeat (6) begin
            step();
            if (int'(count) > peak) peak = int'(count);
        end
        check("bub_peak", peak, 2);
        check("bub_count", count, 2);
        check("bub_head", out_data, 4'hA);
        check("bub_none_out", got.size(), 0);

        // Simultaneous write and read at count 2
        din = 4'hC; in_valid = 1'b1;
        step();
        in_valid = 1'b0; din = '0;
        steps(2);
        out_ready = 1'b1;
        step();
        check("sim_count", count, 2);
        check("sim_head", out_data, 4'hB);
        out_ready = 1'b0;
        step();
        check("sim_hold", count, 2);
        out_ready = 1'b1;
        steps(2);
        check("sim_drained", empty, 1);
        check_got("sim_order", '{4'hA, 4'hB, 4'hC});

        // Reset mid-operation: three stored, two in flight
        out_ready = 1'b0;
        got.delete();
        for (int k = 0; k < 5; k++) begin
            din = WIDTH'(k + 1); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0; din = '0;
        step();
        check("mid_count", count, 3);
        check("mid_head", out_data, 4'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ce", ce, 1);
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("mid_no_stale", out_valid, 0);
        end
        check("mid_none_out", got.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
